// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_pkg
//  Description : Definitions shared by the K=3 convolutional encoder and the
//                matching Viterbi decoder. The generator polynomials live
//                here so that both ends of the link always use the same code.
//                Contents:
//                  K, G0_DEF, G1_DEF : code constants
//                  pair_t            : one coded pair, {c1, c0}
//                  enc_state_t       : encoder frame-control states
//  Revision    : 1.0  initial release
// ============================================================================
package viterbi_pkg;

    // Constraint length and default generators. Tap bit 2 is the current
    // input, bit 1 the newest stored bit and bit 0 the oldest stored bit.
    localparam int          K      = 3;
    localparam logic [2:0]  G0_DEF = 3'b111;
    localparam logic [2:0]  G1_DEF = 3'b101;

    // Coded pair: bit 0 = c0, bit 1 = c1. The decoder's rx_pair input uses
    // the same order.
    typedef logic [1:0] pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : conv_enc_core
//  Description : Combinational rate-1/2 K=3 encoder step. Given the current
//                input bit and the two-bit shift register, it produces the
//                coded pair and the next shift-register value.
//  Ports       : u       in  1  current information bit
//                sr      in  2  shift register, sr[0] newest, sr[1] oldest
//                pair    out 2  coded pair {c1, c0}
//                sr_next out 2  shift register after this bit
//  Revision    : 1.0  initial release
// ============================================================================
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEF,
    parameter logic [2:0] G1 = G1_DEF
) (
    input  logic       u,
    input  logic [1:0] sr,
    output pair_t      pair,
    output logic [1:0] sr_next
);

    // Window ordered to match the generator tap numbering:
    // bit 2 = u, bit 1 = newest stored bit, bit 0 = oldest stored bit.
    logic [2:0] w_window;

    assign w_window = {u, sr[0], sr[1]};
    assign pair     = {^(w_window & G1), ^(w_window & G0)};
    assign sr_next  = {sr[0], u};

endmodule
`default_nettype wire

// File: rtl/conv_encoder_k3.sv
`default_nettype none
// ============================================================================
//  Module      : conv_encoder_k3
//  Description : Framed rate-1/2 K=3 convolutional encoder. It encodes
//                frame_len information bits from a valid/ready stream, then
//                appends two zero tail bits that return the trellis to
//                state 0. Each bit yields one coded pair in a single-slot
//                output register.
//  Ports       : clk        in  1      rising-edge clock
//                rst_n      in  1      asynchronous active-low reset
//                start      in  1      begin a frame (honoured in IDLE only)
//                frame_len  in  LEN_W  information bits in the frame
//                in_valid   in  1      in_bit is valid
//                in_bit     in  1      information bit
//                in_ready   out 1      in_bit is accepted this cycle
//                out_valid  out 1      out_pair is valid
//                out_pair   out 2      coded pair {c1, c0}
//                out_last   out 1      final (second tail) pair of the frame
//                out_ready  in  1      downstream accepts out_pair
//                busy       out 1      not in IDLE
//                done       out 1      last pair of the frame accepted
//  Revision    : 1.0  initial release
// ============================================================================
module conv_encoder_k3
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0    = G0_DEF,
    parameter logic [2:0] G1    = G1_DEF,
    parameter int         LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_pair,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    enc_state_t       r_state;
    enc_state_t       w_state_next;

    logic [1:0]       r_sr;
    logic [LEN_W-1:0] r_bit_cnt;
    logic             r_tail_cnt;
    logic             r_out_valid;
    pair_t            r_out_pair;
    logic             r_out_last;

    logic             w_slot_free;
    logic             w_handshake;
    logic             w_in_ready;
    logic             w_frame_start;
    logic             w_load;
    logic             w_load_last;
    logic             w_u;
    logic             w_cnt_dec;
    logic             w_tail_inc;
    logic             w_done;
    pair_t            w_pair;
    logic [1:0]       w_sr_next;

    // The slot can take a new pair whenever it is empty or being emptied
    // this very cycle, which is what gives one pair per clock at full rate.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_handshake = r_out_valid && out_ready;

    conv_enc_core #(
        .G0      (G0),
        .G1      (G1)
    ) u_core (
        .u       (w_u),
        .sr      (r_sr),
        .pair    (w_pair),
        .sr_next (w_sr_next)
    );

    // ------------------------------------------------------------------
    // Frame control: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame control: next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_in_ready    = 1'b0;
        w_frame_start = 1'b0;
        w_load        = 1'b0;
        w_load_last   = 1'b0;
        w_u           = 1'b0;
        w_cnt_dec     = 1'b0;
        w_tail_inc    = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_frame_start = 1'b1;
                    w_state_next  = (frame_len == '0) ? TAIL : DATA;
                end
            end

            DATA: begin
                w_in_ready = w_slot_free;
                if (in_valid && w_slot_free) begin
                    w_load    = 1'b1;
                    w_u       = in_bit;
                    w_cnt_dec = 1'b1;
                    // The counter is never zero here: an empty frame
                    // skips DATA, so it cannot wrap even at full length.
                    if (r_bit_cnt == LEN_W'(1)) begin
                        w_state_next = TAIL;
                    end
                end
            end

            TAIL: begin
                // u stays 0: the two tail bits flush the register to zero.
                if (w_slot_free) begin
                    w_load     = 1'b1;
                    w_tail_inc = 1'b1;
                    if (r_tail_cnt) begin
                        w_load_last  = 1'b1;
                        w_state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (w_handshake && r_out_last) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, counters and output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pair  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_bit_cnt  <= frame_len;
                r_sr       <= '0;
                r_tail_cnt <= 1'b0;
            end

            if (w_cnt_dec) begin
                r_bit_cnt <= r_bit_cnt - LEN_W'(1);
            end

            // One-bit tail counter: the second increment returns it to 0,
            // so it is already clear for the next frame.
            if (w_tail_inc) begin
                r_tail_cnt <= ~r_tail_cnt;
            end

            // A load in the same cycle as a handshake keeps the slot full.
            if (w_load) begin
                r_sr        <= w_sr_next;
                r_out_pair  <= w_pair;
                r_out_valid <= 1'b1;
                r_out_last  <= w_load_last;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_pair  = r_out_pair;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);
    assign done      = w_done;

endmodule
`default_nettype wire
